// File: rtl/csignal_arbiter_if.sv
// Handshake bundle between NREQ producers, the round-robin slot and one consumer.
// master = producers/consumer side, slave = the arbiter.
interface csignal_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int datawidth = 8,
  parameter int idwidth   = 2,
  parameter int cntwidth  = 16
);
  logic [NREQ-1:0]           req;
  logic [NREQ*datawidth-1:0] req_data;
  logic [NREQ-1:0]           ack;
  logic                      output_en;
  logic                      output_rdy;
  logic [datawidth-1:0]      output_data;
  logic [idwidth-1:0]        output_src;
  logic [cntwidth-1:0]       post_count;

  modport master (
    output req, req_data, output_en,
    input  ack, output_rdy, output_data, output_src, post_count
  );

  modport slave (
    input  req, req_data, output_en,
    output ack, output_rdy, output_data, output_src, post_count
  );
endinterface

// File: rtl/csignal_arbiter.sv
// Round-robin arbiter that funnels NREQ producers into one csignal slot
// with ready/enable consumer semantics and an accepted-signal counter.
module csignal_arbiter #(
  parameter int NREQ      = 4,
  parameter int datawidth = 8,
  parameter int idwidth   = 2,
  parameter int cntwidth  = 16
) (
  input  logic               clk,
  input  logic               reset,
  csignal_arbiter_if.slave   bus
);

  logic                 vld_p0;
  logic [datawidth-1:0] value_p0;
  logic [idwidth-1:0]   src_p0;
  logic [idwidth-1:0]   ptr_p0;
  logic [cntwidth-1:0]  count_p0;

  logic                 consume;
  logic                 can_accept;
  logic                 grant;
  logic                 found;
  logic [idwidth-1:0]   winner;
  logic [idwidth-1:0]   cand;
  logic [idwidth-1:0]   ptr_next;
  logic [datawidth-1:0] payload;
  logic [NREQ-1:0]      ack_vec;
  int                   scan;

  assign consume    = bus.output_en && vld_p0;
  assign can_accept = !vld_p0 || consume;
  assign grant      = can_accept && found && !reset;

  // Scan from ptr upward with an explicit wrap at NREQ so non-power-of-two
  // producer counts never land on a nonexistent index.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    scan   = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan = int'(ptr_p0) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      cand = idwidth'(scan);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    payload = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == idwidth'(i)) payload = bus.req_data[i*datawidth +: datawidth];
    end
  end

  assign ptr_next = (winner == idwidth'(NREQ-1)) ? '0 : winner + 1'b1;

  always_comb begin
    ack_vec = '0;
    if (grant) ack_vec[winner] = 1'b1;
  end

  // Slot register stage: capture on grant, otherwise drain on consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      value_p0 <= '0;
      src_p0   <= '0;
      ptr_p0   <= '0;
      count_p0 <= '0;
    end else if (grant) begin
      vld_p0   <= 1'b1;
      value_p0 <= payload;
      src_p0   <= winner;
      ptr_p0   <= ptr_next;
      count_p0 <= count_p0 + cntwidth'(1);
    end else begin
      vld_p0   <= vld_p0 && !bus.output_en;
    end
  end

  assign bus.ack         = ack_vec;
  assign bus.output_rdy  = vld_p0;
  assign bus.output_data = value_p0;
  assign bus.output_src  = src_p0;
  assign bus.post_count  = count_p0;

endmodule

// File: doc/csignal_arbiter.md
Name: csignal_arbiter

Overview:
- Round-robin scheduler that shares one Impulse C signal slot between NREQ producer processes.
- Each producer posts a data word with a level request. The arbiter grants one producer per accept cycle and latches its word and index into the slot.
- The slot is then presented to a single consumer with the csignal ready/enable semantics.
- Sits between several hardware processes and one consuming process, replacing per-producer signal instances when the consumer waits on "any producer".

Parameters:
- NREQ, 4, number of requesting producers (1..16, any value, not only powers of two).
- datawidth, 8, width of the signal payload.
- idwidth, 2, width of the source index; must satisfy 2^idwidth >= NREQ.
- cntwidth, 16, width of the accepted-signal counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  req[i]=1: producer i has a signal to post.
- req_data  input  NREQ*datawidth  payload of producer i in bits [i*datawidth +: datawidth].
- ack  output  NREQ  one-hot; ack[i]=1: producer i's payload is captured at this clock edge.
- output_en  input  1  consumer takes the pending signal this cycle.
- output_rdy  output  1  a signal is pending in the slot.
- output_data  output  datawidth  payload of the pending signal.
- output_src  output  idwidth  index of the producer that posted the pending signal.
- post_count  output  cntwidth  number of signals accepted since reset.

Behaviour:
- State:
  - signaled (1 bit)
  - value
  - src
  - ptr (round-robin pointer, 0..NREQ-1)
  - count
- Reset (synchronous, reset=1 at a rising edge):
  - signaled=0, value=0, src=0, ptr=0, count=0.
  - Outputs follow: output_rdy=0, output_data=0, output_src=0, post_count=0.
  - ack is forced to all-zero in any cycle where reset=1.
- consume = output_en && signaled. output_en while signaled=0 is ignored.
- can_accept = !signaled || consume. Accept and consume in the same cycle are allowed, giving one signal per cycle throughput.
- Grant selection (combinational):
  - Winner is the first i with req[i]=1, scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - ack[winner]=1 only when can_accept && |req && !reset; all other ack bits are 0.
  - ack never depends on output_rdy of another cycle, only on current-cycle state.
- On an edge with a grant:
  - value <= payload[winner]; src <= winner; signaled <= 1.
  - ptr <= winner+1, wrapping from NREQ-1 to 0.
  - count <= count+1, wrapping modulo 2^cntwidth.
- On an edge without a grant: signaled <= signaled && !output_en. value, src, ptr and count hold.
- Latency:
  - Request to output_rdy: 1 cycle when the slot is free.
  - Data is visible on output_data the cycle after ack.
- Producer rules:
  - Hold req[i] and payload stable until ack[i] is seen at a clock edge.
  - After the ack, the producer may drop req, or keep it high to post again. A re-post is re-arbitrated at lowest priority because ptr has moved past i.
  - Dropping req before ack withdraws the request; nothing is latched.
- Full slot (signaled=1, output_en=0): no ack, all requests stall, and ptr holds, so fairness is preserved.
- Back-pressure is lossless: a producer's signal is never overwritten before it is consumed.
- NREQ=1: ptr stays 0, and the arbiter degenerates to a single csignal with ack.
- Non-power-of-two NREQ: ptr must never take values >= NREQ; the wrap is explicit, not a modulo-2^idwidth overflow.
- Reset mid-operation: a pending signal is discarded with no ack, and producers must re-request. The ack given in the cycle reset deasserts follows normal rules using ptr=0.

Test Plan:
- Reset then idle: after reset, hold req=0 for 5 cycles -> output_rdy=0, output_data=0, output_src=0, post_count=0, ack=0000.
- Single post: NREQ=4, req=0100, data2=0x5A, output_en=0 -> ack=0100 in that cycle; the next cycle shows output_rdy=1, output_data=0x5A, output_src=2, post_count=1. Assert output_en one cycle -> output_rdy=0.
- Full stall: slot holding 0x5A, output_en=0, req=0001 held 3 cycles -> ack=0000 throughout. Assert output_en -> ack=0001 in the same cycle; the next cycle shows output_data equal to producer 0's payload, output_src=0.
- Round-robin fairness: req=1111 held, output_en=1 every cycle, payloads 0x10/0x11/0x12/0x13 -> output_src sequence 0,1,2,3,0,1 on consecutive cycles, one ack per cycle.
- Wrap and non-power-of-two: NREQ=3, req=111 with output_en=1 -> output_src sequence 0,1,2,0; ptr never reaches 3. cntwidth=2: after 5 accepts, post_count=1.
- Reset mid-operation: slot pending with src=3 and req=1000 held; assert reset for 1 cycle -> ack=0000 during reset and output_rdy=0 after it. In the following cycle ack=1000 and output_src=3 on the cycle after that.
